systolic_deskew_collector: RTL and testbench

SYSTOLIC_DESKEW_COLLECTOR -- requirements
Module: systolic_deskew_collector

---
 rtl/systolic_deskew_collector.sv | 120 ++++++++++++
 tb/tb_systolic_deskew_collector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_deskew_collector.sv
// Deskews a systolic array's staircase output into aligned rows and buffers
// them in a small FIFO with tile-row tracking and a sticky overflow flag.

module systolic_deskew_lane #(
   parameter int W     = 16,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [DEPTH-1:0][W-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DEPTH-1];
endmodule

module systolic_deskew_collector #(
   parameter int LANES      = 16,
   parameter int LANE_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int ROWS       = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic [LANES*LANE_WIDTH-1:0]          in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [LANES*LANE_WIDTH-1:0]          out_data,
   output logic                                 out_last,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
   output logic                                 overflow,
   input  logic                                 clr_ovf
);
   localparam int LW  = $clog2(FIFO_DEPTH+1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [LANES-1:0][LANE_WIDTH-1:0] in_lanes;
   logic [LANES-1:0][LANE_WIDTH-1:0] aligned;
   logic [LANES-2:0]                 vld_pipe;
   logic                             aligned_valid;

   assign in_lanes = in_data;

   // Lane k arrives k cycles late, so it waits LANES-1-k stages; the last lane is already aligned.
   for (genvar k = 0; k < LANES-1; k++) begin : g_lane
      systolic_deskew_lane #(
         .W     (LANE_WIDTH),
         .DEPTH (LANES-1-k)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .d   (in_lanes[k]),
         .q   (aligned[k])
      );
   end
   assign aligned[LANES-1] = in_lanes[LANES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_valid;
         for (int i = 1; i < LANES-1; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end
   assign aligned_valid = vld_pipe[LANES-2];

   logic [LANES*LANE_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic [RCW-1:0]              row_cnt;
   logic                        full, push, pop, drop;

   assign full      = (fifo_level == LW'(FIFO_DEPTH));
   assign out_valid = (fifo_level != '0);
   assign pop       = out_valid & out_ready;
   // A full FIFO still takes the row when a pop frees a slot in the same cycle.
   assign push      = aligned_valid & (~full | pop);
   assign drop      = aligned_valid & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= aligned;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         row_cnt    <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (pop) row_cnt <= (row_cnt == RCW'(ROWS-1)) ? '0 : row_cnt + RCW'(1);
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   // Storage is not reset, so mask the read while empty.
   assign out_data = out_valid ? mem[rd_ptr] : '0;
   assign out_last = out_valid & (row_cnt == RCW'(ROWS-1));
endmodule

// File: tb/tb_systolic_deskew_collector.sv
// Scoreboard bench: a queue-level model of the deskew + FIFO predicts levels,
// flags and the ordered stream of accepted rows; a monitor checks every output.

module tb_systolic_deskew_collector;
   localparam int L = 4;
   localparam int W = 8;
   localparam int D = 4;
   localparam int R = 3;
   localparam int NH = 4096;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic [L*W-1:0]     in_data;
   logic               out_valid;
   logic               out_ready;
   logic [L*W-1:0]     out_data;
   logic               out_last;
   logic [2:0]         fifo_level;
   logic               overflow;
   logic               clr_ovf;

   systolic_deskew_collector #(
      .LANES(L), .LANE_WIDTH(W), .FIFO_DEPTH(D), .ROWS(R)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference state: row history by issue cycle, buffered rows, expected output stream.
   bit          hist_v   [NH];
   logic [31:0] hist_row [NH];
   int          cur = 0;
   logic [31:0] mq [$];
   logic [32:0] exp_q [$];
   bit          m_ovf = 0;
   int          acc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cur, act, exp);
      end
   endtask

   // One clock cycle: drive skewed lanes from history, then advance the model after the edge.
   task automatic cyc(input bit v, input logic [31:0] row, input bit rdy, input bit clr);
      logic [31:0] d;
      bit pop, av, full, drop;
      hist_v[cur]   = v;
      hist_row[cur] = row;
      for (int k = 0; k < L; k++) begin
         if (cur >= k && hist_v[cur-k]) d[k*W +: W] = hist_row[cur-k][k*W +: W];
         else                          d[k*W +: W] = W'($urandom);
      end
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      pop  = (mq.size() > 0) && rdy;
      av   = (cur >= L-1) && hist_v[cur-(L-1)];
      full = (mq.size() == D);
      drop = 0;
      if (pop) void'(mq.pop_front());
      if (av) begin
         if (!full || pop) begin
            mq.push_back(hist_row[cur-(L-1)]);
            exp_q.push_back({((acc % R) == R-1), hist_row[cur-(L-1)]});
            acc++;
         end else drop = 1;
      end
      if (drop)     m_ovf = 1;
      else if (clr) m_ovf = 0;
      #1;
      cur++;
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("overflow",   64'(overflow),   64'(m_ovf));
      chk("out_valid",  64'(out_valid),  64'(mq.size() != 0));
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(0, 32'h0, rdy, 0);
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "_last"},  64'(out_last),  64'd0);
      chk({nm, "_level"}, 64'(fifo_level), 64'd0);
      chk({nm, "_ovf"},   64'(overflow),  64'd0);
      chk({nm, "_data"},  64'(out_data),  64'd0);
   endtask

   // Asynchronous reset pulse lasting one cycle; the in-flight rows are forgotten.
   task automatic reset_pulse();
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk_zero_outputs("async_rst");
      @(posedge clk);
      #1;
      chk_zero_outputs("rst_held");
      rst = 1'b0;
      mq.delete();
      exp_q.delete();
      m_ovf = 0;
      acc = 0;
      for (int i = 0; i < L; i++) if (cur >= i) hist_v[cur-i] = 0;
      cur++;
   endtask

   // Monitor: every presented row is checked against the head of the expected stream.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_row", 64'(out_data), 64'hDEAD);
            end else begin
               e = exp_q[0];
               chk("out_data", 64'(out_data), 64'(e[31:0]));
               chk("out_last", 64'(out_last), 64'(e[32]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] r;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst = 1'b0;
      cur = 0;

      // single row issued at cycle 10
      idle(10, 1);
      cyc(1, 32'h13121110, 1, 0);
      idle(3, 1);
      chk("single_valid_c14", 64'(out_valid), 64'd1);
      chk("single_data_c14", 64'(out_data), 64'h13121110);
      idle(1, 1);
      chk("single_level_c15", 64'(fifo_level), 64'd0);
      idle(4, 1);

      // streaming: 6 back-to-back rows
      for (int i = 0; i < 6; i++) cyc(1, $urandom, 1, 0);
      idle(8, 1);

      // backpressure: 4 rows fill, 5th dropped, then drain
      for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0);
      idle(4, 0);
      chk("bp_full", 64'(fifo_level), 64'd4);
      chk("bp_no_ovf", 64'(overflow), 64'd0);
      cyc(1, 32'hBADBAD00, 0, 0);
      idle(4, 0);
      chk("bp_ovf", 64'(overflow), 64'd1);
      idle(8, 1);
      cyc(0, 32'h0, 1, 1);
      idle(2, 1);

      // full with simultaneous pop: 5th row aligns on the single ready cycle
      for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0);
      idle(2, 0);
      cyc(0, 32'h0, 1, 0);
      idle(2, 0);
      chk("fullpop_level", 64'(fifo_level), 64'd4);
      chk("fullpop_ovf", 64'(overflow), 64'd0);
      idle(8, 1);

      // clear race: clr_ovf coincides with the drop, then clears alone
      for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0);
      idle(2, 0);
      cyc(0, 32'h0, 0, 1);
      chk("clr_race_ovf", 64'(overflow), 64'd1);
      idle(2, 0);
      cyc(0, 32'h0, 0, 1);
      chk("clr_alone_ovf", 64'(overflow), 64'd0);
      idle(8, 1);

      // reset two cycles after a row enters the delay line
      cyc(1, 32'hA5A5A5A5, 1, 0);
      idle(1, 1);
      reset_pulse();
      for (int i = 0; i < 8; i++) begin
         cyc(0, 32'h0, 1, 0);
         chk_zero_outputs("post_rst");
      end

      // randomized traffic with gaps, backpressure and occasional clears
      for (int i = 0; i < 500; i++) begin
         r = $urandom;
         cyc($urandom_range(0, 99) < 60, r, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
      end

      // drain with a bounded budget
      for (int i = 0; i < 20 && (mq.size() != 0 || i < L+1); i++) cyc(0, 32'h0, 1, 0);
      chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
